// File: rtl/fifo_arb_pkg.sv
// Shared types, default parameters and the round-robin index helper for the
// FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int N_REQ_DEF     = 4;
    localparam int WIDTH_DEF     = 16;
    localparam int MAX_BURST_DEF = 8;
    localparam int IDLE_TMO_DEF  = 4;

    localparam int ID_W = $clog2(N_REQ_DEF);
    localparam int BC_W = $clog2(MAX_BURST_DEF + 1);
    localparam int IC_W = $clog2(IDLE_TMO_DEF + 1);

    // First set bit of req scanning last_win+1, last_win+2, ... modulo n_req
    // (n_req <= 8); returns last_win when nothing is requesting.
    function automatic logic [2:0] rr_pick_idx(input logic [7:0] req,
                                               input logic [2:0] last_win,
                                               input int         n_req);
        logic [2:0] idx;
        logic       found;
        int         cand;
        idx   = last_win;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cand = (int'(last_win) + k) % n_req;
            if ((k <= n_req) && !found && req[cand[2:0]]) begin
                found = 1'b1;
                idx   = cand[2:0];
            end else begin
                idx   = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: reports whether anyone requests and which
// requester follows last_win in rotating priority order.
module fifo_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEF,
    localparam int GID_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [GID_W-1:0] i_last_win,
    output logic             o_any_req,
    output logic [GID_W-1:0] o_win_idx
);

    // Rotate-and-priority-encode
    always_comb begin
        o_any_req = |i_req;
        o_win_idx = GID_W'(rr_pick_idx(8'(i_req), 3'(i_last_win), N_REQ));
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one FIFO write port among N_REQ
// producers; never raises winc while the FIFO reports full.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int N_REQ     = N_REQ_DEF,
    parameter  int WIDTH     = WIDTH_DEF,
    parameter  int MAX_BURST = MAX_BURST_DEF,
    parameter  int IDLE_TMO  = IDLE_TMO_DEF,
    localparam int GID_W     = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_cfg_en,
    input  logic [N_REQ-1:0]       i_req_valid,
    input  logic [N_REQ-1:0]       i_req_last,
    input  logic [N_REQ*WIDTH-1:0] i_req_data,
    output logic [N_REQ-1:0]       o_req_ready,
    input  logic                   i_fifo_wfull,
    output logic                   o_fifo_winc,
    output logic [WIDTH-1:0]       o_fifo_wdata,
    output logic [GID_W-1:0]       o_grant_id,
    output logic                   o_busy,
    output logic                   o_burst_done
);

    localparam int BCNT_W = $clog2(MAX_BURST + 1);
    localparam int ICNT_W = $clog2(IDLE_TMO + 1);

    arb_state_e        r_state,      w_state_nxt;
    logic [GID_W-1:0]  r_grant_id,   w_grant_id_nxt;
    logic [GID_W-1:0]  r_last_win,   w_last_win_nxt;
    logic              r_busy,       w_busy_nxt;
    logic [BCNT_W-1:0] r_beat_cnt,   w_beat_cnt_nxt;
    logic [ICNT_W-1:0] r_idle_cnt,   w_idle_cnt_nxt;
    logic              r_burst_done, w_burst_done_nxt;

    logic              w_any_req;
    logic [GID_W-1:0]  w_pick;
    logic              w_lock;
    logic              w_valid_g;
    logic              w_last_g;
    logic              w_exit;
    logic [BCNT_W-1:0] w_beat_inc;
    logic [ICNT_W-1:0] w_idle_inc;

    fifo_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .i_req      (i_req_valid),
        .i_last_win (r_last_win),
        .o_any_req  (w_any_req),
        .o_win_idx  (w_pick)
    );

    // Owner-selected valid/last/data and the write-port handshake
    always_comb begin
        w_lock       = (r_state == LOCK);
        w_valid_g    = 1'b0;
        w_last_g     = 1'b0;
        o_fifo_wdata = {WIDTH{1'b0}};
        o_req_ready  = {N_REQ{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            o_req_ready[i] = w_lock & ~i_fifo_wfull & (r_grant_id == GID_W'(i));
            w_valid_g      = w_valid_g | ((r_grant_id == GID_W'(i)) & i_req_valid[i]);
            w_last_g       = w_last_g  | ((r_grant_id == GID_W'(i)) & i_req_last[i]);
            o_fifo_wdata   = o_fifo_wdata |
                             ({WIDTH{w_lock & (r_grant_id == GID_W'(i))}} & i_req_data[i*WIDTH +: WIDTH]);
        end
        o_fifo_winc = w_lock & w_valid_g & ~i_fifo_wfull;
    end

    // Grant/release decisions and counter updates
    always_comb begin
        w_state_nxt      = r_state;
        w_grant_id_nxt   = r_grant_id;
        w_last_win_nxt   = r_last_win;
        w_busy_nxt       = r_busy;
        w_beat_cnt_nxt   = r_beat_cnt;
        w_idle_cnt_nxt   = r_idle_cnt;
        w_burst_done_nxt = 1'b0;
        w_exit           = 1'b0;
        w_beat_inc       = r_beat_cnt + BCNT_W'(1);
        w_idle_inc       = r_idle_cnt + ICNT_W'(1);
        case (r_state)
            IDLE: begin
                if (i_cfg_en && w_any_req) begin
                    w_state_nxt    = LOCK;
                    w_grant_id_nxt = w_pick;
                    w_last_win_nxt = w_pick;
                    w_busy_nxt     = 1'b1;
                    w_beat_cnt_nxt = {BCNT_W{1'b0}};
                    w_idle_cnt_nxt = {ICNT_W{1'b0}};
                end else begin
                    w_state_nxt    = IDLE;
                end
            end
            LOCK: begin
                if (o_fifo_winc) begin
                    w_beat_cnt_nxt = w_beat_inc;
                    w_idle_cnt_nxt = {ICNT_W{1'b0}};
                    w_exit         = w_last_g || (w_beat_inc == BCNT_W'(MAX_BURST));
                end else if (!w_valid_g) begin
                    w_idle_cnt_nxt = w_idle_inc;
                    w_exit         = (w_idle_inc == ICNT_W'(IDLE_TMO));
                end else begin
                    // FIFO full with data pending: both counters hold
                    w_exit         = 1'b0;
                end
                if (w_exit) begin
                    w_state_nxt      = IDLE;
                    w_busy_nxt       = 1'b0;
                    w_burst_done_nxt = 1'b1;
                end else begin
                    w_state_nxt      = LOCK;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_grant_id   <= {GID_W{1'b0}};
            r_last_win   <= GID_W'(N_REQ - 1);
            r_busy       <= 1'b0;
            r_beat_cnt   <= {BCNT_W{1'b0}};
            r_idle_cnt   <= {ICNT_W{1'b0}};
            r_burst_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant_id   <= w_grant_id_nxt;
            r_last_win   <= w_last_win_nxt;
            r_busy       <= w_busy_nxt;
            r_beat_cnt   <= w_beat_cnt_nxt;
            r_idle_cnt   <= w_idle_cnt_nxt;
            r_burst_done <= w_burst_done_nxt;
        end
    end

    assign o_grant_id   = r_grant_id;
    assign o_busy       = r_busy;
    assign o_burst_done = r_burst_done;

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the synchronous-pointer FIFO (winc/wdata/wfull) among N_REQ producers in the write-clock domain.
- Grants are round-robin and burst-locked: a winner keeps the port until its last beat, until MAX_BURST beats, or until it idles for IDLE_TMO cycles.
- Never asserts winc while wfull is high, because the FIFO's SRAM writes on winc regardless of the full flag.
- Emits the winning requester ID alongside each beat for downstream tagging.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 16, data width; matches the FIFO word.
- MAX_BURST, 8, maximum beats per grant (1..64).
- IDLE_TMO, 4, consecutive no-valid cycles inside a grant before forced release (>=1).

Ports:
- clk  in  1  FIFO write clock.
- rst_n  in  1  async active-low reset.
- cfg_en  in  1  arbitration enable.
- req_valid  in  N_REQ  per-requester beat valid.
- req_last  in  N_REQ  per-requester last beat of burst; qualified by valid.
- req_data  in  N_REQ*WIDTH  packed data; requester i occupies [i*WIDTH +: WIDTH].
- req_ready  out  N_REQ  per-requester accept, one-hot or zero.
- fifo_wfull  in  1  FIFO full flag.
- fifo_winc  out  1  FIFO write enable.
- fifo_wdata  out  WIDTH  FIFO write data.
- grant_id  out  clog2(N_REQ)  current owner; valid while busy.
- busy  out  1  grant held.
- burst_done  out  1  one-cycle pulse on the cycle a grant ends.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
  - Reset values: state=IDLE, busy=0, grant_id=0, beat_cnt=0, idle_cnt=0, burst_done=0, last_win=N_REQ-1 (so requester 0 wins first).
  - fifo_winc, fifo_wdata and req_ready are combinational, so they read 0 during reset.
  - Reset mid-burst abandons the burst; no partial-state recovery.
- States: IDLE, LOCK.
- IDLE:
  - If cfg_en and any req_valid: pick the first valid requester scanning last_win+1, last_win+2, ... modulo N_REQ.
  - Register grant_id, last_win, busy=1, beat_cnt=0, idle_cnt=0; go to LOCK.
  - Arbitration latency is 1 cycle: no transfer in the grant cycle.
- LOCK:
  - req_ready[g] = ~fifo_wfull (g = grant_id); all other ready bits are 0.
  - fifo_winc = req_valid[g] & ~fifo_wfull.
  - fifo_wdata = req_data[g] whenever in LOCK (don't-care otherwise; drive 0).
  - A beat transfers when fifo_winc=1. Each beat increments beat_cnt and clears idle_cnt.
  - Cycles with req_valid[g]=0 increment idle_cnt.
  - Cycles with valid=1 and wfull=1 (stall) hold both counters.
- LOCK exit to IDLE, in priority order:
  - a beat with req_last[g];
  - a beat that makes beat_cnt==MAX_BURST;
  - idle_cnt reaching IDLE_TMO.
  - On exit: burst_done=1 for the exit cycle's next clock, busy=0.
  - Re-arbitration happens in the following IDLE cycle, giving one bubble cycle between grants.
- cfg_en=0 does not break a LOCK. It only blocks new grants in IDLE.
- wfull stall has no timeout. A grant may wait indefinitely on a full FIFO.
- Requesters must hold data and last stable while valid and not ready. The arbiter does not check this.
- Widths:
  - beat_cnt is clog2(MAX_BURST+1) bits.
  - idle_cnt is clog2(IDLE_TMO+1) bits.
  - The last_win+k scan wraps modulo N_REQ; no overflow is possible.
- Simultaneous last beat and idle timeout cannot occur, because a beat clears idle_cnt. Last and MAX_BURST on the same beat count as one exit.

Decomposition:
- Package fifo_arb_pkg:
  - state enum {IDLE, LOCK};
  - localparams ID_W=clog2(N_REQ), BC_W, IC_W;
  - a function for the rotate-and-priority-encode index.
- One sub-module, fifo_rr_pick: combinational round-robin picker.
  - Inputs: req vector and last_win.
  - Outputs: any_req and the winner index.
- All sequential state lives in fifo_wr_arbiter.

Test Plan:
- Reset, then req_valid=4'b0001 with data 16'hA000..A002, last on the 3rd beat:
  - grant_id=0 one cycle later, 3 consecutive winc;
  - burst_done pulses once; busy drops; FIFO holds A000, A001, A002.
- req_valid=4'b1111, each requester sending 2-beat bursts:
  - grant order 0,1,2,3,0 with one bubble between grants;
  - no two ready bits high in the same cycle.
- Single requester sends 10 beats with no last, MAX_BURST=8:
  - release after the 8th beat;
  - re-grant to the same requester (sole valid) after one bubble; remaining 2 beats follow.
- fifo_wfull forced high for 5 cycles mid-burst with valid held:
  - winc=0 and ready=0 for exactly those 5 cycles; beat_cnt unchanged;
  - transfer resumes on the cycle wfull=0; no data lost or duplicated.
- Granted requester drops valid after 1 beat:
  - after 4 idle cycles (IDLE_TMO=4) burst_done pulses;
  - a waiting requester 2 is granted next.
- Assert rst_n=0 mid-LOCK, then release with req 1 and 3 valid:
  - busy=0 during reset; first grant goes to requester 1 (last_win reset to 3).
